// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth multiplier sequencing stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package booth_pkg;

    localparam int TIMEOUT_OFS = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

endpackage

// File: rtl/booth_wd_timer.sv
// Watchdog up-counter: sync clear, enable, terminal count at TIMEOUT-1.
// Latency: count updates one cycle after clr/en; tc decodes the current count.
// Backpressure: none; counts whenever enabled.
module booth_wd_timer #(
    parameter int TIMEOUT = 14
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clr,
    input  logic                         en,
    output logic [$clog2(TIMEOUT):0]     count,
    output logic                         tc
);

    localparam int W = $clog2(TIMEOUT) + 1;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign tc = (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequencer in front of the multi-cycle Booth multiplier: latch operands, strobe restart, collect product.
// Latency: accept -> CLEAR -> RUN; result valid the cycle after a qualified done, or TIMEOUT+2 after accept on timeout.
// Backpressure: one op in flight; in_ready_o low from accept until the result handshake completes.
module booth_seq_ctrl
    import booth_pkg::*;
#(
    parameter int N       = 8,
    parameter int TIMEOUT = N + TIMEOUT_OFS
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [N:0]       a_i,
    input  logic [N:0]       b_i,
    output logic [N:0]       mul_a_o,
    output logic [N:0]       mul_b_o,
    output logic             mul_clr_o,
    input  logic             mul_done_i,
    input  logic [2*N+1:0]   mul_y_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [2*N+1:0]   out_y_o,
    output logic             err_o
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    state_e          state;
    state_e          state_nxt;
    logic [TW-1:0]   tmr_count;
    logic            tmr_tc;
    logic            accept;
    logic            done_q;
    logic            res_hs;
    logic            run_exit;

    assign accept   = in_valid_i & in_ready_o;
    // The first RUN cycle ignores done: it may still be the previous op's flag.
    assign done_q   = mul_done_i & (tmr_count != '0);
    assign res_hs   = out_valid_o & out_ready_i;
    assign run_exit = (state == ST_RUN) & (done_q | tmr_tc);

    booth_wd_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wd_timer (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (state == ST_CLEAR),
        .en    (state == ST_RUN),
        .count (tmr_count),
        .tc    (tmr_tc)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept)   state_nxt = ST_CLEAR;
            ST_CLEAR:               state_nxt = ST_RUN;
            ST_RUN:   if (run_exit) state_nxt = ST_HOLD;
            ST_HOLD:  if (res_hs)   state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= ST_IDLE;
            in_ready_o  <= 1'b0;
            mul_a_o     <= '0;
            mul_b_o     <= '0;
            mul_clr_o   <= 1'b0;
            out_valid_o <= 1'b0;
            out_y_o     <= '0;
            err_o       <= 1'b0;
        end else begin
            state      <= state_nxt;
            // Registered decodes of the next state keep every output flop-driven.
            in_ready_o <= (state_nxt == ST_IDLE);
            mul_clr_o  <= (state_nxt == ST_CLEAR);

            if (accept) begin
                mul_a_o <= a_i;
                mul_b_o <= b_i;
                err_o   <= 1'b0;
            end

            if (run_exit) begin
                out_valid_o <= 1'b1;
                if (done_q) begin
                    out_y_o <= mul_y_i;
                end else begin
                    out_y_o <= '0;
                    err_o   <= 1'b1;
                end
            end else if (res_hs) begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: doc/booth_seq_ctrl.md
# booth_seq_ctrl

Sequencing stage directly upstream of the multi-cycle Booth multiplier. Accepts signed operand pairs over a valid/ready stream and holds them stable on the multiplier inputs. Strobes the multiplier's restart, waits for its done flag, and returns the product on a valid/ready result stream. A watchdog flags a multiplier that never finishes.

## Interface
- N, default 8: operand msb index; operands are N+1 bits, two's complement; product is 2N+2 bits.
- TIMEOUT, default N+6: maximum RUN cycles waited for done before error.

- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- in_valid_i  in  1  operand pair offered
- in_ready_o  out  1  operand pair accepted this cycle when high with in_valid_i
- a_i  in  N+1  multiplicand
- b_i  in  N+1  multiplier
- mul_a_o  out  N+1  multiplicand to multiplier, held stable
- mul_b_o  out  N+1  multiplier to multiplier, held stable
- mul_clr_o  out  1  active-high one-cycle restart strobe to the multiplier
- mul_done_i  in  1  multiplier done flag
- mul_y_i  in  2N+2  multiplier product
- out_valid_o  out  1  result available
- out_ready_i  in  1  consumer takes result
- out_y_o  out  2N+2  product, signed
- err_o  out  1  last operation timed out

## Operation
- FSM states: IDLE, CLEAR, RUN, HOLD.
- **IDLE:**
  - in_ready_o=1.
  - On in_valid_i&in_ready_o: register a_i→mul_a_o and b_i→mul_b_o; clear err_o; go to CLEAR.
- **CLEAR:**
  - mul_clr_o=1 for exactly this one cycle.
  - Timer←0.
  - mul_done_i is ignored.
  - Go to RUN.
- **RUN:**
  - Timer increments each cycle.
  - mul_done_i is qualified only when timer≥1, which masks a stale done from the previous operation.
  - On qualified done: out_y_o←mul_y_i, out_valid_o←1, go to HOLD.
  - If timer reaches TIMEOUT-1 without done: out_y_o←0, err_o←1, out_valid_o←1, go to HOLD.
  - Done and timeout in the same cycle: done wins, err_o stays 0.
- **HOLD:**
  - out_valid_o, out_y_o and err_o are held.
  - On out_valid_o&out_ready_i: out_valid_o←0, go to IDLE.
- **Invariants:**
  - in_ready_o=0 in CLEAR, RUN and HOLD, so only one operation is in flight.
  - mul_a_o and mul_b_o change only on input acceptance and never during CLEAR, RUN or HOLD.
  - out_y_o changes only on entry to HOLD.
  - err_o is sticky until the next accepted operand.
- **Arithmetic:** none. The product passes through bit-exact; no sign extension or truncation.

## Timing
- Reset value of every output is 0, including in_ready_o (low while rst_i is low).
- State after reset is IDLE; in_ready_o=1 the first cycle after rst_i deasserts.
- Reset mid-operation aborts immediately: no result is produced, mul_clr_o=0, outputs return to 0.
- Cycle timeline, accept at edge k:
  - CLEAR in cycle k+1.
  - RUN from k+2.
  - out_valid_o rises the cycle after the first qualified mul_done_i.
- Timeout case: out_valid_o rises at k+2+TIMEOUT.
- Throughput: one operation per (multiplier latency + 3 + out_ready_i wait) cycles.
- out_ready_i held high in HOLD means the result is valid for exactly 1 cycle.
- A new in_valid_i is seen in IDLE the cycle after the result handshake.
- All outputs are registered, with no combinational path from input to output.

## Structure
- Package booth_pkg holds:
  - the state enum typedef (IDLE, CLEAR, RUN, HOLD);
  - the default TIMEOUT offset constant (6).
- One sub-module, booth_wd_timer: a clearable up-counter with terminal-count output, width $clog2(TIMEOUT)+1, sync clear, enable, async active-low reset.
- Datapath registers (operands, result) are inline in booth_seq_ctrl.

## Test plan
- **Single op:** N=8, multiplier model asserts done 10 cycles after clear; a=5, b=-3 → mul_clr_o one pulse at k+1, out_y_o=-15 (0x3FFF1), err_o=0, valid held until out_ready_i.
- **Extremes:** a=-256, b=-256 → out_y_o=65536. a=255, b=-256 → -65280. Operands are stable throughout RUN.
- **Timeout:** model never asserts done → out_valid_o at k+2+TIMEOUT, out_y_o=0, err_o=1. Next accepted operand clears err_o.
- **Stale done:** mul_done_i held high through CLEAR and the first RUN cycle, then low, then high 10 cycles later → only the later done is captured.
- **Backpressure:** out_ready_i low for 20 cycles with in_valid_i high → in_ready_o stays 0, out_y_o stable; one accept follows the handshake.
- **Reset mid-RUN:** rst_i pulsed low at RUN cycle 4 → all outputs 0 immediately, IDLE after release, no out_valid_o.
